cliente_cajero_secuenciador: RTL

//  Client-side driver for the cajero_automatico interface: takes one transaction command
//  (PIN, type, amount), then drives card insertion, 4 keypad digits and the amount strobe.

---
 rtl/cliente_cajero_secuenciador_pkg.sv | 37 +++
 rtl/cliente_cajero_secuenciador_if.sv | 39 +++
 rtl/cliente_cajero_secuenciador_temporizador.sv | 27 ++
 rtl/cliente_cajero_secuenciador.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cliente_cajero_secuenciador_pkg.sv
// Shared definitions for the ATM client sequencer: FSM states, result codes
// and small helpers used by the top and its timer.
package cliente_cajero_secuenciador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CARD,
    ST_DIGIT,
    ST_GAP,
    ST_PIN_WAIT,
    ST_MONTO,
    ST_RESP_WAIT,
    ST_DONE
  } state_t;

  localparam logic [2:0] RES_DEPOSITO       = 3'd0;
  localparam logic [2:0] RES_RETIRO         = 3'd1;
  localparam logic [2:0] RES_PIN_INCORRECTO = 3'd2;
  localparam logic [2:0] RES_ADVERTENCIA    = 3'd3;
  localparam logic [2:0] RES_BLOQUEO        = 3'd4;
  localparam logic [2:0] RES_FONDOS         = 3'd5;
  localparam logic [2:0] RES_TIMEOUT        = 3'd6;

  // Digit 0 is the most significant nibble of the PIN.
  function automatic logic [3:0] nibble_sel(input logic [15:0] pin, input logic [1:0] idx);
    int sh;
    sh = 12 - 4 * int'(idx);
    return pin[sh +: 4];
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cliente_cajero_secuenciador_if.sv
// Host command, ATM control and ATM status signals of the client sequencer.
// master is the sequencer's view; slave is the host/ATM side.
interface cliente_cajero_secuenciador_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [15:0] CMD_PIN;
  logic        CMD_TIPO;
  logic [31:0] CMD_MONTO;
  logic        TARJETA_RECIBIDA;
  logic        TIPO_TRANS;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        PIN_INCORRECTO;
  logic        ADVERTENCIA;
  logic        BLOQUEO;
  logic        BALANCE_ACTUALIZADO;
  logic        ENTREGAR_DINERO;
  logic        FONDOS_INSUFICIENTES;
  logic        RES_VALID;
  logic [2:0]  RES_CODE;

  modport master (
    input  CMD_VALID, CMD_PIN, CMD_TIPO, CMD_MONTO,
    input  PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
    input  BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
    output CMD_READY, TARJETA_RECIBIDA, TIPO_TRANS, DIGITO, DIGITO_STB,
    output MONTO, MONTO_STB, RES_VALID, RES_CODE
  );

  modport slave (
    output CMD_VALID, CMD_PIN, CMD_TIPO, CMD_MONTO,
    output PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
    output BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
    input  CMD_READY, TARJETA_RECIBIDA, TIPO_TRANS, DIGITO, DIGITO_STB,
    input  MONTO, MONTO_STB, RES_VALID, RES_CODE
  );
endinterface

// File: rtl/cliente_cajero_secuenciador_temporizador.sv
// Load/count-down timer shared by the digit gap, PIN wait and response wait.
// Loading N-1 makes expired rise on the Nth cycle after the load.
module temporizador_espera #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cliente_cajero_secuenciador.sv
// Client-side ATM driver: accepts one command, inserts the card, keys in the PIN,
// strobes the amount and reports one result code per transaction.
module cliente_cajero_secuenciador
  import cliente_cajero_secuenciador_pkg::*;
#(
  parameter int DIG_GAP      = 4,
  parameter int PIN_WAIT_CYC = 8,
  parameter int TIMEOUT      = 64
) (
  input logic                          clk,
  input logic                          rst,
  cliente_cajero_secuenciador_if.master bus
);

  localparam int TMR_W = $clog2(max3(DIG_GAP, PIN_WAIT_CYC, TIMEOUT) + 1);

  state_t           state;
  state_t           next_state;
  logic [15:0]      pin_reg;
  logic [1:0]       digit_idx;
  logic [2:0]       res_next;
  logic [2:0]       pin_code;
  logic             pin_error;
  logic             handshake;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expired;

  assign handshake = bus.CMD_VALID & bus.CMD_READY;
  assign pin_error = bus.BLOQUEO | bus.ADVERTENCIA | bus.PIN_INCORRECTO;
  assign pin_code  = bus.BLOQUEO     ? RES_BLOQUEO     :
                     bus.ADVERTENCIA ? RES_ADVERTENCIA : RES_PIN_INCORRECTO;

  temporizador_espera #(.W(TMR_W)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    res_next   = RES_DEPOSITO;
    case (state)
      ST_IDLE:      if (handshake) next_state = ST_CARD;
      ST_CARD:      next_state = ST_DIGIT;
      ST_DIGIT: begin
        if (pin_error) begin
          next_state = ST_DONE;
          res_next   = pin_code;
        end else if (digit_idx == 2'd3) begin
          next_state = ST_PIN_WAIT;
        end else begin
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (pin_error) begin
          next_state = ST_DONE;
          res_next   = pin_code;
        end else if (tmr_expired) begin
          next_state = ST_DIGIT;
        end
      end
      ST_PIN_WAIT: begin
        if (pin_error) begin
          next_state = ST_DONE;
          res_next   = pin_code;
        end else if (tmr_expired) begin
          next_state = ST_MONTO;
        end
      end
      ST_MONTO:     next_state = ST_RESP_WAIT;
      // Funds shortage wins; a deposit only ends on the balance update and a
      // withdrawal only on cash delivery.
      ST_RESP_WAIT: begin
        if (bus.FONDOS_INSUFICIENTES) begin
          next_state = ST_DONE;
          res_next   = RES_FONDOS;
        end else if (!bus.TIPO_TRANS && bus.BALANCE_ACTUALIZADO) begin
          next_state = ST_DONE;
          res_next   = RES_DEPOSITO;
        end else if (bus.TIPO_TRANS && bus.ENTREGAR_DINERO) begin
          next_state = ST_DONE;
          res_next   = RES_RETIRO;
        end else if (tmr_expired) begin
          next_state = ST_DONE;
          res_next   = RES_TIMEOUT;
        end
      end
      ST_DONE:      next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.CMD_READY        = (state == ST_IDLE) & rst;
    bus.TARJETA_RECIBIDA = (state != ST_IDLE) && (state != ST_DONE);
    bus.DIGITO_STB       = (state == ST_DIGIT);
    bus.MONTO_STB        = (state == ST_MONTO);
    bus.RES_VALID        = (state == ST_DONE);
    tmr_load             = 1'b0;
    tmr_value            = '0;
    if (state == ST_DIGIT) begin
      tmr_load  = 1'b1;
      tmr_value = (digit_idx == 2'd3) ? TMR_W'(PIN_WAIT_CYC - 1) : TMR_W'(DIG_GAP - 1);
    end else if (state == ST_MONTO) begin
      tmr_load  = 1'b1;
      tmr_value = TMR_W'(TIMEOUT - 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_reg        <= '0;
      digit_idx      <= '0;
      bus.TIPO_TRANS <= 1'b0;
      bus.MONTO      <= '0;
      bus.DIGITO     <= '0;
      bus.RES_CODE   <= '0;
    end else begin
      if (handshake) begin
        pin_reg        <= bus.CMD_PIN;
        bus.TIPO_TRANS <= bus.CMD_TIPO;
        bus.MONTO      <= bus.CMD_MONTO;
        digit_idx      <= '0;
      end
      if (state == ST_DIGIT) digit_idx <= digit_idx + 2'd1;
      if (next_state == ST_DIGIT) bus.DIGITO <= nibble_sel(pin_reg, digit_idx);
      if (next_state == ST_DONE) bus.RES_CODE <= res_next;
    end
  end

endmodule
